scan_ramp_generator: RTL and testbench

Parametrised successor to the 16-bit triangle scan generator. Produces a bounded ramp on q for DAC/lock-point scanning, in one of four modes: triangle, sawtooth, single-shot or hold.
- Clamps exactly at scan_min/scan_max; never overshoots.
- Exposes step and turnaround strobes so downstream sequencers can align acquisition to scan points.
- Sits between the host-register interface and the DAC/PI setpoint mux.

---
 rtl/scan_ramp_generator.sv | 168 ++++++++++++++++
 tb/tb_scan_ramp_generator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ramp_generator.sv
// Bounded scan ramp (triangle / sawtooth / single-shot / hold) with step and turnaround strobes.
// Define SCAN_DWELL_EN to add the dwell port and per-point dwell counter.
module scan_ramp_generator #(
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sinit,
  input  logic               scan_enable,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   increment,
  input  logic [WIDTH-1:0]   scan_min,
  input  logic [WIDTH-1:0]   scan_max,
`ifdef SCAN_DWELL_EN
  input  logic [DWELL_W-1:0] dwell,
`endif
  output logic [WIDTH-1:0]   q,
  output logic               direction,
  output logic               step_strobe,
  output logic               turn_strobe,
  output logic               done,
  output logic               cfg_err
);

  if (WIDTH < 1 || DWELL_W < 1) begin : g_bad_param
    $error("WIDTH and DWELL_W must be positive");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_TRI  = 2'd0;
  localparam logic [1:0] M_SAW  = 2'd1;
  localparam logic [1:0] M_ONE  = 2'd2;
  localparam logic [1:0] M_HOLD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             turn_q, turn_d;
  logic             done_q, done_d;
  logic             run_ok;
  logic             step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign cfg_err = (scan_min > scan_max);

  // Advancing is allowed whenever the inputs would put the FSM in RUN; DONE blocks it.
  assign run_ok = (state_q != ST_DONE) && scan_enable && (mode != M_HOLD) && !cfg_err;

  // One extra bit so a carry above the top or a borrow below zero is visible.
  assign sum  = {1'b0, q_q} + {1'b0, increment};
  assign diff = {1'b0, q_q} - {1'b0, increment};

`ifdef SCAN_DWELL_EN
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign step = run_ok && (dwell_q == '0);

  always_comb begin
    dwell_d = dwell_q;
    if (sinit)       dwell_d = '0;
    else if (step)   dwell_d = dwell;
    else if (run_ok) dwell_d = dwell_q - DWELL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  assign step = run_ok;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dir_d   = dir_q;
    done_d  = done_q;
    step_d  = 1'b0;
    turn_d  = 1'b0;
    if (sinit) begin
      q_d     = scan_min;
      dir_d   = 1'b1;
      done_d  = 1'b0;
      state_d = scan_enable ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (scan_enable && mode != M_HOLD) state_d = ST_RUN;
        ST_RUN:  if (!scan_enable || mode == M_HOLD) state_d = ST_IDLE;
        default: if (mode != M_ONE) state_d = (scan_enable && mode != M_HOLD) ? ST_RUN : ST_IDLE;
      endcase
      if (step) begin
        step_d = 1'b1;
        // A window moved under q: snap to the violated bound without adding this step.
        if (q_q > scan_max) begin
          q_d    = scan_max;
          turn_d = 1'b1;
          dir_d  = (mode != M_TRI);
          if (mode == M_ONE) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (q_q < scan_min) begin
          q_d    = scan_min;
          turn_d = 1'b1;
          dir_d  = 1'b1;
        end else if (mode == M_TRI && !dir_q) begin
          if (diff[WIDTH] || diff[WIDTH-1:0] < scan_min) begin
            q_d    = scan_min;
            dir_d  = 1'b1;
            turn_d = 1'b1;
          end else begin
            q_d = diff[WIDTH-1:0];
          end
        end else begin
          dir_d = 1'b1;
          if (sum > {1'b0, scan_max}) begin
            turn_d = 1'b1;
            unique case (mode)
              M_SAW: q_d = scan_min;
              M_ONE: begin
                q_d     = scan_max;
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
              default: begin
                q_d   = scan_max;
                dir_d = 1'b0;
              end
            endcase
          end else begin
            q_d = sum[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      turn_q  <= turn_d;
      done_q  <= done_d;
    end
  end

  assign q           = q_q;
  assign direction   = dir_q;
  assign step_strobe = step_q;
  assign turn_strobe = turn_q;
  assign done        = done_q;

endmodule

// File: tb/tb_scan_ramp_generator.sv
// Bench for scan_ramp_generator: directed scan sequences plus randomized traffic against a behavioural model.
module tb_scan_ramp_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sinit;
  logic        scan_enable;
  logic [1:0]  mode;
  logic [15:0] increment;
  logic [15:0] scan_min;
  logic [15:0] scan_max;
  logic [15:0] dwell_v;
  logic [15:0] q;
  logic        direction;
  logic        step_strobe;
  logic        turn_strobe;
  logic        done;
  logic        cfg_err;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  longint m_q;
  bit     m_dir, m_step, m_turn, m_done, m_fin;
  int     m_cnt;

  int tri_q[7] = '{14, 18, 20, 16, 12, 10, 14};
  int tri_t[7] = '{0, 0, 1, 0, 0, 1, 0};

  scan_ramp_generator #(.WIDTH(16), .DWELL_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sinit       (sinit),
    .scan_enable (scan_enable),
    .mode        (mode),
    .increment   (increment),
    .scan_min    (scan_min),
    .scan_max    (scan_max),
`ifdef SCAN_DWELL_EN
    .dwell       (dwell_v),
`endif
    .q           (q),
    .direction   (direction),
    .step_strobe (step_strobe),
    .turn_strobe (turn_strobe),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_dir = 1'b1; m_step = 1'b0; m_turn = 1'b0;
    m_done = 1'b0; m_fin = 1'b0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_clk();
    longint lo, hi, v, inc, n;
    lo = longint'(scan_min);
    hi = longint'(scan_max);
    inc = longint'(increment);
    v = m_q;
    m_step = 1'b0;
    m_turn = 1'b0;
    if (sinit) begin
      m_q = lo; m_dir = 1'b1; m_done = 1'b0; m_fin = 1'b0; m_cnt = 0;
      return;
    end
    if (m_fin) begin
      if (mode != 2'd2) m_fin = 1'b0;
      return;
    end
    if (!scan_enable || mode == 2'd3 || lo > hi) return;
    if (m_cnt > 0) begin
      m_cnt--;
      return;
    end
    m_cnt = int'(dwell_v);
    m_step = 1'b1;
    if (v > hi) begin
      m_q = hi; m_turn = 1'b1; m_dir = (mode != 2'd0);
      if (mode == 2'd2) begin m_fin = 1'b1; m_done = 1'b1; end
    end else if (v < lo) begin
      m_q = lo; m_turn = 1'b1; m_dir = 1'b1;
    end else if (mode == 2'd0 && !m_dir) begin
      n = v - inc;
      if (n < lo) begin m_q = lo; m_dir = 1'b1; m_turn = 1'b1; end
      else m_q = n;
    end else begin
      m_dir = 1'b1;
      n = v + inc;
      if (n > hi) begin
        m_turn = 1'b1;
        case (mode)
          2'd1: m_q = lo;
          2'd2: begin m_q = hi; m_fin = 1'b1; m_done = 1'b1; end
          default: begin m_q = hi; m_dir = 1'b0; end
        endcase
      end else begin
        m_q = n;
      end
    end
  endtask

  task automatic compare_all();
    chk("q", 32'(q), 32'(m_q));
    chk("direction", 32'(direction), 32'(m_dir));
    chk("step_strobe", 32'(step_strobe), 32'(m_step));
    chk("turn_strobe", 32'(turn_strobe), 32'(m_turn));
    chk("done", 32'(done), 32'(m_done));
    chk("cfg_err", 32'(cfg_err), 32'(scan_min > scan_max));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clk();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; sinit = 1'b0; scan_enable = 1'b0; mode = 2'd0;
    increment = '0; scan_min = '0; scan_max = '0; dwell_v = '0;
    model_reset();
    cyc();
    cyc();
    chk("reset_q", 32'(q), 0);
    chk("reset_dir", 32'(direction), 1);
    rst_n = 1'b1;

    // Triangle 10..20 step 4
    mode = 2'd0; scan_min = 16'd10; scan_max = 16'd20; increment = 16'd4;
    scan_enable = 1'b1; sinit = 1'b1;
    cyc();
    chk("tri_init", 32'(q), 10);
    sinit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("tri_q", 32'(q), 32'(tri_q[i]));
      chk("tri_turn", 32'(turn_strobe), 32'(tri_t[i]));
    end

    // Sawtooth full range, carry-out wraps
    mode = 2'd1; scan_min = 16'h0000; scan_max = 16'hFFFF; increment = 16'h8000; sinit = 1'b1;
    cyc();
    chk("saw_init", 32'(q), 0);
    sinit = 1'b0;
    cyc();
    chk("saw_q1", 32'(q), 32'h8000);
    chk("saw_t1", 32'(turn_strobe), 0);
    cyc();
    chk("saw_wrap_q", 32'(q), 0);
    chk("saw_wrap_t", 32'(turn_strobe), 1);
    cyc();
    chk("saw_q3", 32'(q), 32'h8000);

    // Single-shot 0..5 step 2
    mode = 2'd2; scan_min = 16'd0; scan_max = 16'd5; increment = 16'd2; sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    cyc(); chk("ss_q1", 32'(q), 2);
    cyc(); chk("ss_q2", 32'(q), 4);
    cyc(); chk("ss_q3", 32'(q), 5); chk("ss_done", 32'(done), 1); chk("ss_turn", 32'(turn_strobe), 1);
    cyc(); cyc();
    chk("ss_hold_q", 32'(q), 5); chk("ss_sticky", 32'(done), 1); chk("ss_nostep", 32'(step_strobe), 0);
    sinit = 1'b1;
    cyc(); chk("ss_reinit_q", 32'(q), 0); chk("ss_reinit_done", 32'(done), 0);
    sinit = 1'b0;

    // Async reset between edges, then window shrink below q
    mode = 2'd0; scan_min = 16'd0; scan_max = 16'd100; increment = 16'd10; sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    cyc(); cyc(); cyc();
    #1 rst_n = 1'b0;
    #1 model_reset();
    chk("arst_q", 32'(q), 0);
    chk("arst_dir", 32'(direction), 1);
    chk("arst_step", 32'(step_strobe), 0);
    chk("arst_turn", 32'(turn_strobe), 0);
    #1 rst_n = 1'b1;
    sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("shrink_pre", 32'(q), 50);
    scan_max = 16'd30;
    cyc(); chk("shrink_q", 32'(q), 30); chk("shrink_turn", 32'(turn_strobe), 1); chk("shrink_dir", 32'(direction), 0);
    cyc(); chk("shrink_next", 32'(q), 20);

    // Corners: zero increment, degenerate window, bad window
    scan_min = 16'd5; scan_max = 16'd50; increment = 16'd0; sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    cyc(); chk("inc0_q", 32'(q), 5); chk("inc0_step", 32'(step_strobe), 1); chk("inc0_turn", 32'(turn_strobe), 0);
    scan_min = 16'd7; scan_max = 16'd7; increment = 16'd3; sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    cyc(); chk("eq_q1", 32'(q), 7); chk("eq_t1", 32'(turn_strobe), 1); chk("eq_d1", 32'(direction), 0);
    cyc(); chk("eq_q2", 32'(q), 7); chk("eq_t2", 32'(turn_strobe), 1); chk("eq_d2", 32'(direction), 1);
    scan_min = 16'd9; scan_max = 16'd3;
    cyc(); chk("cfg_err", 32'(cfg_err), 1); chk("cfg_nostep", 32'(step_strobe), 0); chk("cfg_q", 32'(q), 7);

`ifdef SCAN_DWELL_EN
    mode = 2'd0; scan_min = 16'd0; scan_max = 16'd1000; increment = 16'd1; dwell_v = 16'd2; sinit = 1'b1;
    cyc();
    sinit = 1'b0;
    cyc(); chk("dw_s1", 32'(step_strobe), 1);
    cyc(); chk("dw_s2", 32'(step_strobe), 0);
    cyc(); chk("dw_s3", 32'(step_strobe), 0);
    cyc(); chk("dw_s4", 32'(step_strobe), 1);
    cyc(); chk("dw_s5", 32'(step_strobe), 0);
    scan_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(); chk("dw_paused", 32'(step_strobe), 0); end
    scan_enable = 1'b1;
    cyc(); chk("dw_resume0", 32'(step_strobe), 0);
    cyc(); chk("dw_resume1", 32'(step_strobe), 1); chk("dw_q", 32'(q), 3);
    dwell_v = '0;
`endif

    // Randomized traffic against the model
    scan_min = 16'd20; scan_max = 16'd90; increment = 16'd7; mode = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      sinit = ($urandom_range(0, 31) == 0);
      scan_enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 15))
          0, 1, 2, 3, 4, 5:   mode = 2'd0;
          6, 7, 8, 9, 10:     mode = 2'd1;
          11, 12, 13:         mode = 2'd2;
          default:            mode = 2'd3;
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          scan_min = 16'd0; scan_max = 16'hFFFF;
          increment = 16'($urandom_range(0, 16'hFFFF));
        end else begin
          scan_min = 16'($urandom_range(0, 100));
          scan_max = 16'(int'(scan_min) + $urandom_range(0, 120));
          increment = 16'($urandom_range(0, 30));
          if ($urandom_range(0, 7) == 0) begin
            scan_max = scan_min - 16'd1 - 16'($urandom_range(0, 5));
          end
        end
      end
`ifdef SCAN_DWELL_EN
      dwell_v = 16'($urandom_range(0, 3));
`endif
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
